mipi_csi_rx_packet_decoder_8b2lane: RTL and testbench

//  Upstream stage for the RAW depacker. Parses 2-lane, 8-bit-gear CSI-2 byte stream from lane aligner.

---
 rtl/mipi_csi_pkg.sv | 29 ++
 rtl/mipi_csi_rx_packet_decoder_8b2lane_if.sv | 33 +++
 rtl/mipi_csi_rx_packet_decoder_8b2lane.sv | 124 ++++++++++++
 tb/tb_mipi_csi_rx_packet_decoder_8b2lane.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mipi_csi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mipi_csi_pkg
//  Description : CSI-2 data-type codes and header-parser state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
package mipi_csi_pkg;

  localparam logic [5:0] c_dt_fs        = 6'h00;
  localparam logic [5:0] c_dt_fe        = 6'h01;
  localparam logic [5:0] c_dt_short_lim = 6'h10;
  localparam logic [5:0] c_dt_raw10     = 6'h2B;
  localparam logic [5:0] c_dt_raw12     = 6'h2C;
  localparam logic [5:0] c_dt_raw14     = 6'h2D;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_B   = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_SKIP    = 3'd3,
    ST_TRAIL   = 3'd4
  } state_t;

  function automatic logic is_raw_dt(input logic [5:0] dt);
    return (dt == c_dt_raw10) || (dt == c_dt_raw12) || (dt == c_dt_raw14);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mipi_csi_rx_packet_decoder_8b2lane_if.sv
`default_nettype none
// ============================================================================
//  Module      : mipi_csi_rx_packet_decoder_8b2lane_if
//  Description : Aligned 2-lane byte stream in, RAW payload words and strobes out
//  Revision    : 1.0 - initial release
// ============================================================================
interface mipi_csi_rx_packet_decoder_8b2lane_if;

  logic        data_valid_i;
  logic [15:0] data_i;
  logic        data_valid_o;
  logic [15:0] data_o;
  logic [2:0]  packet_type_o;
  logic        frame_start_o;
  logic        frame_end_o;
  logic        packet_error_o;

  // decoder side
  modport slave (
    input  data_valid_i, data_i,
    output data_valid_o, data_o, packet_type_o,
           frame_start_o, frame_end_o, packet_error_o
  );

  // lane-aligner / depacker side
  modport master (
    output data_valid_i, data_i,
    input  data_valid_o, data_o, packet_type_o,
           frame_start_o, frame_end_o, packet_error_o
  );

endinterface
`default_nettype wire

// File: rtl/mipi_csi_rx_packet_decoder_8b2lane.sv
`default_nettype none
// ============================================================================
//  Module      : mipi_csi_rx_packet_decoder_8b2lane
//  Description : Strips CSI-2 header/CRC, forwards RAW10/12/14 payload words,
//                decodes FS/FE short packets into strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module mipi_csi_rx_packet_decoder_8b2lane
  import mipi_csi_pkg::*;
#(
  parameter logic [1:0] VC_ID    = 2'd0,
  parameter int         WC_WIDTH = 16
) (
  input  wire logic clk_i,
  input  wire logic reset_i,
  mipi_csi_rx_packet_decoder_8b2lane_if.slave bus
);

  localparam logic [WC_WIDTH-1:0] c_two = WC_WIDTH'(2);

  state_t              r_state;
  logic [7:0]          r_di;
  logic [7:0]          r_wc_l;
  logic [WC_WIDTH-1:0] r_cnt;
  logic                r_data_valid;
  logic [15:0]         r_data;
  logic [2:0]          r_packet_type;
  logic                r_frame_start;
  logic                r_frame_end;
  logic                r_packet_error;

  logic [WC_WIDTH-1:0] w_wc;
  logic [5:0]          w_dt;
  logic                w_vc_ok;
  logic                w_cnt_last;
  logic [WC_WIDTH-1:0] w_cnt_next;

  assign w_wc       = WC_WIDTH'({bus.data_i[7:0], r_wc_l});
  assign w_dt       = r_di[5:0];
  assign w_vc_ok    = (r_di[7:6] == VC_ID);
  // Saturating decrement: an odd count ends at 1, never wraps
  assign w_cnt_last = (r_cnt <= c_two);
  assign w_cnt_next = w_cnt_last ? '0 : (r_cnt - c_two);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state        <= ST_IDLE;
      r_di           <= '0;
      r_wc_l         <= '0;
      r_cnt          <= '0;
      r_data_valid   <= 1'b0;
      r_data         <= '0;
      r_packet_type  <= '0;
      r_frame_start  <= 1'b0;
      r_frame_end    <= 1'b0;
      r_packet_error <= 1'b0;
    end else begin
      r_data_valid   <= 1'b0;
      r_data         <= '0;
      r_frame_start  <= 1'b0;
      r_frame_end    <= 1'b0;
      r_packet_error <= 1'b0;
      if (!bus.data_valid_i) begin
        // Burst ended: truncation is only an error while payload is still owed
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        if (r_state == ST_PAYLOAD || r_state == ST_SKIP) begin
          r_packet_error <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_di    <= bus.data_i[7:0];
            r_wc_l  <= bus.data_i[15:8];
            r_state <= ST_HDR_B;
          end
          ST_HDR_B: begin
            if (w_dt < c_dt_short_lim) begin
              r_frame_start <= w_vc_ok && (w_dt == c_dt_fs);
              r_frame_end   <= w_vc_ok && (w_dt == c_dt_fe);
              r_state       <= ST_TRAIL;
            end else if (is_raw_dt(w_dt) && w_vc_ok && (w_wc != '0)) begin
              r_packet_type <= w_dt[2:0];
              r_cnt         <= w_wc;
              r_state       <= ST_PAYLOAD;
            end else begin
              r_cnt   <= w_wc;
              r_state <= ST_SKIP;
            end
          end
          ST_PAYLOAD: begin
            r_data_valid <= 1'b1;
            r_data       <= bus.data_i;
            r_cnt        <= w_cnt_next;
            if (w_cnt_last) begin
              r_state <= ST_TRAIL;
            end
          end
          ST_SKIP: begin
            r_cnt <= w_cnt_next;
            if (w_cnt_last) begin
              r_state <= ST_TRAIL;
            end
          end
          ST_TRAIL: begin
            r_state <= ST_TRAIL;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.data_valid_o   = r_data_valid;
  assign bus.data_o         = r_data;
  assign bus.packet_type_o  = r_packet_type;
  assign bus.frame_start_o  = r_frame_start;
  assign bus.frame_end_o    = r_frame_end;
  assign bus.packet_error_o = r_packet_error;

endmodule
`default_nettype wire

// File: tb/tb_mipi_csi_rx_packet_decoder_8b2lane.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mipi_csi_rx_packet_decoder_8b2lane
//  Description : Directed self-checking bench for the CSI-2 packet decoder
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mipi_csi_rx_packet_decoder_8b2lane;

  logic clk_i;
  logic reset_i;
  int   n_checks;
  int   n_fail;

  mipi_csi_rx_packet_decoder_8b2lane_if u_if ();

  mipi_csi_rx_packet_decoder_8b2lane #(
    .VC_ID    (2'd0),
    .WC_WIDTH (16)
  ) u_dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (u_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one beat, then return 1 time unit after the edge that samples it
  task automatic beat(input logic v, input logic [15:0] d);
    u_if.data_valid_i = v;
    u_if.data_i       = d;
    @(posedge clk_i);
    #1;
  endtask

  task automatic short_pkt(input logic [7:0] di, input logic exp_fs, input logic exp_fe);
    beat(1'b1, {8'h00, di});
    chk("short_a_fs", u_if.frame_start_o, 0);
    beat(1'b1, {8'h3F, 8'h00});
    chk("short_fs", u_if.frame_start_o, exp_fs);
    chk("short_fe", u_if.frame_end_o, exp_fe);
    chk("short_dv", u_if.data_valid_o, 0);
    beat(1'b0, 16'h0000);
    chk("short_fs_clr", u_if.frame_start_o, 0);
    chk("short_fe_clr", u_if.frame_end_o, 0);
  endtask

  // Sends header plus n_sent payload beats; a short n_sent truncates the burst
  task automatic long_pkt(input logic [7:0] di, input logic [15:0] wc, input int n_sent,
                          input logic accept, input logic [2:0] exp_type);
    int          n_words;
    logic [15:0] w;
    n_words = (int'(wc) + 1) / 2;
    beat(1'b1, {wc[7:0], di});
    chk("hdr_a_dv", u_if.data_valid_o, 0);
    beat(1'b1, {8'hE5, wc[15:8]});
    chk("hdr_type", u_if.packet_type_o, exp_type);
    chk("hdr_b_dv", u_if.data_valid_o, 0);
    for (int i = 0; i < n_sent; i++) begin
      w = 16'(32'(i) * 32'h0203) ^ {di, 8'h5A};
      beat(1'b1, w);
      chk("pl_dv", u_if.data_valid_o, accept);
      chk("pl_data", u_if.data_o, accept ? w : 16'h0000);
      chk("pl_err", u_if.packet_error_o, 0);
    end
    if (n_sent < n_words) begin
      beat(1'b0, 16'h0000);
      chk("cut_err", u_if.packet_error_o, 1);
      chk("cut_dv", u_if.data_valid_o, 0);
      beat(1'b0, 16'h0000);
      chk("cut_err_clr", u_if.packet_error_o, 0);
    end else begin
      beat(1'b1, 16'hC1C0);
      chk("crc_dv", u_if.data_valid_o, 0);
      chk("crc_data", u_if.data_o, 0);
      beat(1'b0, 16'h0000);
      chk("end_dv", u_if.data_valid_o, 0);
      chk("end_err", u_if.packet_error_o, 0);
    end
    chk("end_type", u_if.packet_type_o, exp_type);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_i  = 1'b1;
    u_if.data_valid_i = 1'b0;
    u_if.data_i       = 16'h0000;
    beat(1'b0, 16'h0000);
    beat(1'b0, 16'h0000);
    chk("rst_dv", u_if.data_valid_o, 0);
    chk("rst_data", u_if.data_o, 0);
    chk("rst_type", u_if.packet_type_o, 0);
    chk("rst_fs", u_if.frame_start_o, 0);
    chk("rst_fe", u_if.frame_end_o, 0);
    chk("rst_err", u_if.packet_error_o, 0);
    reset_i = 1'b0;
    beat(1'b0, 16'h0000);

    // Frame start on own VC, then on a foreign VC (ignored)
    short_pkt(8'h00, 1'b1, 1'b0);
    short_pkt(8'h40, 1'b0, 1'b0);

    // RAW10, even and odd word counts
    long_pkt(8'h2B, 16'h000A, 5, 1'b1, 3'd3);
    long_pkt(8'h2B, 16'h0005, 3, 1'b1, 3'd3);

    // RAW12 then RAW14 back to back with a single idle cycle
    long_pkt(8'h2C, 16'h0006, 3, 1'b1, 3'd4);
    long_pkt(8'h2D, 16'h000E, 7, 1'b1, 3'd5);

    // Non-RAW long packet and RAW10 on VC1 are skipped, type held
    long_pkt(8'h12, 16'h0008, 4, 1'b0, 3'd5);
    long_pkt(8'h6B, 16'h0008, 4, 1'b0, 3'd5);

    // Truncated RAW10, then a truncated skipped packet, then recovery
    long_pkt(8'h2B, 16'h0014, 4, 1'b1, 3'd3);
    long_pkt(8'h12, 16'h0010, 2, 1'b0, 3'd3);
    long_pkt(8'h2C, 16'h0004, 2, 1'b1, 3'd4);

    // Full-scale word count
    long_pkt(8'h2D, 16'hFFFF, 32768, 1'b1, 3'd5);

    // Reset in the middle of a payload
    beat(1'b1, {8'h08, 8'h2C});
    beat(1'b1, {8'hE5, 8'h00});
    beat(1'b1, 16'h1234);
    chk("pre_rst_dv", u_if.data_valid_o, 1);
    reset_i = 1'b1;
    beat(1'b1, 16'h5678);
    chk("mid_rst_dv", u_if.data_valid_o, 0);
    chk("mid_rst_data", u_if.data_o, 0);
    chk("mid_rst_type", u_if.packet_type_o, 0);
    chk("mid_rst_err", u_if.packet_error_o, 0);
    reset_i = 1'b0;
    beat(1'b0, 16'h0000);
    chk("post_rst_err", u_if.packet_error_o, 0);
    short_pkt(8'h01, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
